ifid_ctrl: RTL and testbench

IF/ID pipeline register plus ID-stage control-flow resolution for the 5-stage MIPS core. It latches the fetched instruction and PC+4, and decodes branches and jumps in ID. It detects load-use and branch-operand hazards and drives the fetch stage's `stall`, `flush`, `pc_src_id`, `branch_addr_id` and `jump_addr_id`. It also owns external-interrupt entry (synchroniser, pending FSM, EPC capture).

---
 rtl/mips_pkg.sv | 50 +++++
 rtl/id_hazard_unit.sv | 41 ++++
 rtl/ifid_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_ifid_ctrl.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg: shared MIPS ID-stage constants and types.
//   - opcode / funct encodings for the control-flow instructions decoded in ID
//   - next-PC select codes (PCSRC_*)
//   - external-interrupt FSM state enum
//   - I-type field view of an instruction word and the branch-target helper
// -----------------------------------------------------------------------------
package mips_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned REG_W   = 5;
    localparam int unsigned PCSRC_W = 3;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_BLEZ  = 6'h06;
    localparam logic [5:0] OP_BGTZ  = 6'h07;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_JALR  = 6'h09;

    localparam logic [PCSRC_W-1:0] PCSRC_SEQ    = 3'd0;
    localparam logic [PCSRC_W-1:0] PCSRC_BRANCH = 3'd1;
    localparam logic [PCSRC_W-1:0] PCSRC_JUMP   = 3'd2;
    localparam logic [PCSRC_W-1:0] PCSRC_TRAP   = 3'd3;

    typedef enum logic [1:0] {
        IRQ_IDLE = 2'd0,
        IRQ_PEND = 2'd1,
        IRQ_MASK = 2'd2
    } irq_state_e;

    // I-type view of an instruction word
    typedef struct packed {
        logic [5:0]       opcode;
        logic [REG_W-1:0] rs;
        logic [REG_W-1:0] rt;
        logic [15:0]      imm;
    } instr_i_t;

    // PC+4 plus sign-extended word offset, wrapping modulo 2^32
    function automatic logic [XLEN-1:0] branch_target(input logic [XLEN-1:0] pc4,
                                                      input logic [15:0]     imm);
        return pc4 + {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/id_hazard_unit.sv
// -----------------------------------------------------------------------------
// id_hazard_unit: combinational ID-stage hazard detection.
//   Inputs : id_rs/id_rt      source fields of the instruction in ID
//            id_is_jtype      ID holds j/jal (no register sources)
//            id_is_ctrl       ID holds a branch, jr or jalr (resolved in ID)
//            ex_mem_read, ex_reg_write, ex_rd   EX-stage producer info
//            mem_mem_read, mem_rd               MEM-stage producer info
//   Output : stall            load-use or branch-operand hazard present
// -----------------------------------------------------------------------------
module id_hazard_unit
    import mips_pkg::*;
(
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_is_jtype,
    input  logic             id_is_ctrl,
    input  logic             ex_mem_read,
    input  logic             ex_reg_write,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             mem_mem_read,
    input  logic [REG_W-1:0] mem_rd,
    output logic             stall
);

    logic ex_match;
    logic mem_match;
    logic load_use;
    logic branch_haz;

    // $0 is never a real dependency
    always_comb begin
        ex_match   = (ex_rd != '0) && ((ex_rd == id_rs) || (ex_rd == id_rt));
        mem_match  = (mem_rd != '0) && ((mem_rd == id_rs) || (mem_rd == id_rt));
        load_use   = ex_mem_read && ex_match && !id_is_jtype;
        // Compare/jr operands are needed in ID, so a result still in EX, or a
        // load still in MEM, cannot be forwarded in time.
        branch_haz = id_is_ctrl && ((ex_reg_write && ex_match) || (mem_mem_read && mem_match));
        stall      = load_use || branch_haz;
    end

endmodule

// File: rtl/ifid_ctrl.sv
// -----------------------------------------------------------------------------
// ifid_ctrl: IF/ID pipeline register with ID-stage branch/jump resolution,
// hazard stall generation and external-interrupt entry.
//   Config : `IFID_IRQ_EN enables the irq synchroniser, pending FSM and EPC;
//            when undefined irq is ignored and irq_ack/epc are tied to 0.
//   Param  : IRQ_SYNC_STAGES  irq synchroniser depth (>= 2)
//   Inputs : clk, reset (async, active-high)
//            instruction_if, pc_plus4_if      fetch stage outputs
//            rs_data_id, rt_data_id           forwarded ID operands
//            ex_mem_read, ex_reg_write, ex_rd, mem_mem_read, mem_rd  hazard info
//            irq                              async level interrupt request
//   Outputs: instruction_id, pc_plus4_id      IF/ID register contents
//            pc_src_id, branch_addr_id, jump_addr_id   next-PC control
//            stall, flush, bubble_id          pipeline control
//            irq_ack, epc                     trap entry pulse / restart address
// -----------------------------------------------------------------------------
module ifid_ctrl
    import mips_pkg::*;
#(
    parameter int unsigned IRQ_SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [XLEN-1:0]      instruction_if,
    input  logic [XLEN-1:0]      pc_plus4_if,
    input  logic [XLEN-1:0]      rs_data_id,
    input  logic [XLEN-1:0]      rt_data_id,
    input  logic                 ex_mem_read,
    input  logic                 ex_reg_write,
    input  logic [REG_W-1:0]     ex_rd,
    input  logic                 mem_mem_read,
    input  logic [REG_W-1:0]     mem_rd,
    input  logic                 irq,
    output logic [XLEN-1:0]      instruction_id,
    output logic [XLEN-1:0]      pc_plus4_id,
    output logic [PCSRC_W-1:0]   pc_src_id,
    output logic [XLEN-1:0]      branch_addr_id,
    output logic [XLEN-1:0]      jump_addr_id,
    output logic                 stall,
    output logic                 flush,
    output logic                 bubble_id,
    output logic                 irq_ack,
    output logic [XLEN-1:0]      epc
);

    logic [XLEN-1:0] instruction_id_q, instruction_id_d;
    logic [XLEN-1:0] pc_plus4_id_q, pc_plus4_id_d;

    instr_i_t ins;
    logic     is_branch;
    logic     is_jtype;
    logic     is_jreg;
    logic     is_ctrl;
    logic     br_taken;
    logic     hz_stall;
    logic     trap_entry;

    assign instruction_id = instruction_id_q;
    assign pc_plus4_id    = pc_plus4_id_q;

    // Decode and target generation for the instruction held in ID
    always_comb begin
        ins       = instr_i_t'(instruction_id_q);
        is_branch = (ins.opcode == OP_BEQ)  || (ins.opcode == OP_BNE) ||
                    (ins.opcode == OP_BLEZ) || (ins.opcode == OP_BGTZ);
        is_jtype  = (ins.opcode == OP_J) || (ins.opcode == OP_JAL);
        is_jreg   = (ins.opcode == OP_RTYPE) &&
                    ((instruction_id_q[5:0] == FN_JR) || (instruction_id_q[5:0] == FN_JALR));
        is_ctrl   = is_branch || is_jreg;

        br_taken = 1'b0;
        case (ins.opcode)
            OP_BEQ:  br_taken = (rs_data_id == rt_data_id);
            OP_BNE:  br_taken = (rs_data_id != rt_data_id);
            OP_BLEZ: br_taken = ($signed(rs_data_id) <= 32'sd0);
            OP_BGTZ: br_taken = ($signed(rs_data_id) >  32'sd0);
            default: br_taken = 1'b0;
        endcase

        branch_addr_id = branch_target(pc_plus4_id_q, ins.imm);
        jump_addr_id   = is_jreg ? rs_data_id
                                 : {pc_plus4_id_q[31:28], instruction_id_q[25:0], 2'b00};
    end

    id_hazard_unit u_hazard (
        .id_rs        (ins.rs),
        .id_rt        (ins.rt),
        .id_is_jtype  (is_jtype),
        .id_is_ctrl   (is_ctrl),
        .ex_mem_read  (ex_mem_read),
        .ex_reg_write (ex_reg_write),
        .ex_rd        (ex_rd),
        .mem_mem_read (mem_mem_read),
        .mem_rd       (mem_rd),
        .stall        (hz_stall)
    );

    // Next-PC / pipeline control: stall > trap > branch/jump > sequential
    always_comb begin
        stall     = 1'b0;
        flush     = 1'b0;
        bubble_id = 1'b0;
        pc_src_id = PCSRC_SEQ;
        if (hz_stall) begin
            stall     = 1'b1;
            bubble_id = 1'b1;
        end else if (trap_entry) begin
            pc_src_id = PCSRC_TRAP;
            flush     = 1'b1;
            bubble_id = 1'b1;
        end else if (is_branch && br_taken) begin
            pc_src_id = PCSRC_BRANCH;
            flush     = 1'b1;
        end else if (is_jtype || is_jreg) begin
            pc_src_id = PCSRC_JUMP;
            flush     = 1'b1;
        end
    end

    // IF/ID register next state
    always_comb begin
        instruction_id_d = hz_stall ? instruction_id_q : instruction_if;
        pc_plus4_id_d    = hz_stall ? pc_plus4_id_q    : pc_plus4_if;
    end

`ifdef IFID_IRQ_EN
    logic [IRQ_SYNC_STAGES-1:0] sync_q, sync_d;
    logic                       irq_prev_q, irq_prev_d;
    irq_state_e                 state_q, state_d;
    logic [XLEN-1:0]            epc_q, epc_d;
    logic                       irq_s;
    logic                       irq_rise;
    logic                       entry_ok;

    // Synchroniser, edge detect and interrupt pending FSM
    always_comb begin
        sync_d     = {sync_q[IRQ_SYNC_STAGES-2:0], irq};
        irq_s      = sync_q[IRQ_SYNC_STAGES-1];
        irq_prev_d = irq_s;
        irq_rise   = irq_s && !irq_prev_q;
        // Entry only on a real, non-control instruction so EPC names a restartable PC
        entry_ok   = !hz_stall && (instruction_id_q != '0) && !is_ctrl && !is_jtype;
        trap_entry = (state_q == IRQ_PEND) && entry_ok;

        state_d = state_q;
        epc_d   = epc_q;
        case (state_q)
            IRQ_IDLE: if (irq_rise) state_d = IRQ_PEND;
            IRQ_PEND: begin
                if (entry_ok) begin
                    state_d = IRQ_MASK;
                    epc_d   = pc_plus4_id_q - XLEN'(4);
                end
            end
            IRQ_MASK: if (!irq_s) state_d = IRQ_IDLE;
            default:  state_d = IRQ_IDLE;
        endcase
    end

    assign irq_ack = trap_entry;
    assign epc     = epc_q;
`else
    logic [1:0] unused_irq;

    assign trap_entry = 1'b0;
    assign irq_ack    = 1'b0;
    assign epc        = '0;
    assign unused_irq = {irq, 1'(IRQ_SYNC_STAGES)};
`endif

    // All state flops
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instruction_id_q <= '0;
            pc_plus4_id_q    <= '0;
`ifdef IFID_IRQ_EN
            sync_q           <= '0;
            irq_prev_q       <= 1'b0;
            state_q          <= IRQ_IDLE;
            epc_q            <= '0;
`endif
        end else begin
            instruction_id_q <= instruction_id_d;
            pc_plus4_id_q    <= pc_plus4_id_d;
`ifdef IFID_IRQ_EN
            sync_q           <= sync_d;
            irq_prev_q       <= irq_prev_d;
            state_q          <= state_d;
            epc_q            <= epc_d;
`endif
        end
    end

endmodule

// File: tb/tb_ifid_ctrl.sv
// -----------------------------------------------------------------------------
// tb_ifid_ctrl: self-checking bench for ifid_ctrl.
// Table of decode/hazard vectors through a scoreboard queue, followed by
// hand-written multi-cycle sequences (stall hold, jr stall, irq entry, reset).
// -----------------------------------------------------------------------------
module tb_ifid_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] instruction_if = '0;
    logic [31:0] pc_plus4_if = '0;
    logic [31:0] rs_data_id = '0;
    logic [31:0] rt_data_id = '0;
    logic        ex_mem_read = 1'b0;
    logic        ex_reg_write = 1'b0;
    logic [4:0]  ex_rd = '0;
    logic        mem_mem_read = 1'b0;
    logic [4:0]  mem_rd = '0;
    logic        irq = 1'b0;
    logic [31:0] instruction_id;
    logic [31:0] pc_plus4_id;
    logic [2:0]  pc_src_id;
    logic [31:0] branch_addr_id;
    logic [31:0] jump_addr_id;
    logic        stall;
    logic        flush;
    logic        bubble_id;
    logic        irq_ack;
    logic [31:0] epc;

    int n_checks = 0;
    int n_fail = 0;

    localparam logic [31:0] ADD = 32'h00411820;  // add $3,$2,$1
    localparam logic [31:0] BEQ = 32'h10220003;  // beq $1,$2,+3

    ifid_ctrl #(.IRQ_SYNC_STAGES(2)) dut (
        .clk            (clk),
        .reset          (reset),
        .instruction_if (instruction_if),
        .pc_plus4_if    (pc_plus4_if),
        .rs_data_id     (rs_data_id),
        .rt_data_id     (rt_data_id),
        .ex_mem_read    (ex_mem_read),
        .ex_reg_write   (ex_reg_write),
        .ex_rd          (ex_rd),
        .mem_mem_read   (mem_mem_read),
        .mem_rd         (mem_rd),
        .irq            (irq),
        .instruction_id (instruction_id),
        .pc_plus4_id    (pc_plus4_id),
        .pc_src_id      (pc_src_id),
        .branch_addr_id (branch_addr_id),
        .jump_addr_id   (jump_addr_id),
        .stall          (stall),
        .flush          (flush),
        .bubble_id      (bubble_id),
        .irq_ack        (irq_ack),
        .epc            (epc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr, pc4, rs_d, rt_d;
        logic        ex_mr, ex_rw;
        logic [4:0]  ex_rd;
        logic        mem_mr;
        logic [4:0]  mem_rd;
        logic        stall, flush, bubble;
        logic [2:0]  pcsrc;
        logic [31:0] baddr, jaddr;
        logic        chk_b, chk_j;
    } vec_t;

    typedef struct {
        int          idx;
        logic [31:0] instr, pc4;
        logic        stall, flush, bubble;
        logic [2:0]  pcsrc;
        logic [31:0] baddr, jaddr;
        logic        chk_b, chk_j;
    } exp_t;

    vec_t vecs[$];
    exp_t sb_q[$];

    function automatic vec_t mk(input logic [31:0] instr, input logic [31:0] pc4,
                                input logic [31:0] rs_d, input logic [31:0] rt_d,
                                input logic ex_mr, input logic ex_rw, input logic [4:0] exrd,
                                input logic mem_mr, input logic [4:0] memrd,
                                input logic st, input logic fl, input logic bu,
                                input logic [2:0] pcs, input logic [31:0] ba,
                                input logic [31:0] ja, input logic cb, input logic cj);
        vec_t v;
        v.instr = instr; v.pc4 = pc4; v.rs_d = rs_d; v.rt_d = rt_d;
        v.ex_mr = ex_mr; v.ex_rw = ex_rw; v.ex_rd = exrd;
        v.mem_mr = mem_mr; v.mem_rd = memrd;
        v.stall = st; v.flush = fl; v.bubble = bu; v.pcsrc = pcs;
        v.baddr = ba; v.jaddr = ja; v.chk_b = cb; v.chk_j = cj;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_hazards();
        ex_mem_read = 1'b0; ex_reg_write = 1'b0; ex_rd = '0;
        mem_mem_read = 1'b0; mem_rd = '0;
    endtask

    task automatic chk_idle_ctrl(input string tag);
        chk({tag, " pc_src"}, 32'(pc_src_id), 32'd0);
        chk({tag, " stall"},  32'(stall),     32'd0);
        chk({tag, " flush"},  32'(flush),     32'd0);
        chk({tag, " bubble"}, 32'(bubble_id), 32'd0);
        chk({tag, " irq_ack"}, 32'(irq_ack),  32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int acks;
        int bad;
        exp_t e;

        // reset state
        #1;
        chk("rst instruction_id", instruction_id, 32'h0);
        chk("rst pc_plus4_id", pc_plus4_id, 32'h0);
        chk("rst epc", epc, 32'h0);
        chk_idle_ctrl("rst");
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;

        //            instr         pc4           rs_d          rt_d         exmr exrw exrd mmr mrd st fl bu pcs  baddr         jaddr         cb cj
        vecs.push_back(mk(BEQ,          32'h100,      32'd5,        32'd5,       0, 0, 5'd0,  0, 5'd0, 0, 1, 0, 3'd1, 32'h10C,      32'h0,        1, 0));
        vecs.push_back(mk(BEQ,          32'h100,      32'd5,        32'd6,       0, 0, 5'd0,  0, 5'd0, 0, 0, 0, 3'd0, 32'h10C,      32'h0,        1, 0));
        vecs.push_back(mk(32'h1022FFFE, 32'h100,      32'd9,        32'd9,       0, 0, 5'd0,  0, 5'd0, 0, 1, 0, 3'd1, 32'hF8,       32'h0,        1, 0));
        vecs.push_back(mk(32'h1422FFFE, 32'h4,        32'd7,        32'd7,       0, 0, 5'd0,  0, 5'd0, 0, 0, 0, 3'd0, 32'hFFFFFFFC, 32'h0,        1, 0));
        vecs.push_back(mk(32'h14220003, 32'h100,      32'd5,        32'd6,       0, 0, 5'd0,  0, 5'd0, 0, 1, 0, 3'd1, 32'h10C,      32'h0,        1, 0));
        vecs.push_back(mk(32'h18200004, 32'h200,      32'd0,        32'd0,       0, 0, 5'd0,  0, 5'd0, 0, 1, 0, 3'd1, 32'h210,      32'h0,        1, 0));
        vecs.push_back(mk(32'h18200004, 32'h200,      32'd1,        32'd0,       0, 0, 5'd0,  0, 5'd0, 0, 0, 0, 3'd0, 32'h210,      32'h0,        1, 0));
        vecs.push_back(mk(32'h18200004, 32'h200,      32'hFFFFFFFF, 32'd0,       0, 0, 5'd0,  0, 5'd0, 0, 1, 0, 3'd1, 32'h210,      32'h0,        1, 0));
        vecs.push_back(mk(32'h1C200004, 32'h200,      32'h80000000, 32'd0,       0, 0, 5'd0,  0, 5'd0, 0, 0, 0, 3'd0, 32'h210,      32'h0,        1, 0));
        vecs.push_back(mk(32'h1C200004, 32'h200,      32'd1,        32'd0,       0, 0, 5'd0,  0, 5'd0, 0, 1, 0, 3'd1, 32'h210,      32'h0,        1, 0));
        vecs.push_back(mk(32'h08000040, 32'h10000010, 32'd0,        32'd0,       0, 0, 5'd0,  0, 5'd0, 0, 1, 0, 3'd2, 32'h0,        32'h10000100, 0, 1));
        vecs.push_back(mk(32'h0C000040, 32'hF0000000, 32'd0,        32'd0,       0, 0, 5'd0,  0, 5'd0, 0, 1, 0, 3'd2, 32'h0,        32'hF0000100, 0, 1));
        vecs.push_back(mk(32'h03E00008, 32'h0,        32'h400,      32'd0,       0, 0, 5'd0,  0, 5'd0, 0, 1, 0, 3'd2, 32'h0,        32'h400,      0, 1));
        vecs.push_back(mk(32'h03E0F809, 32'h0,        32'h1234,     32'd0,       0, 0, 5'd0,  0, 5'd0, 0, 1, 0, 3'd2, 32'h0,        32'h1234,     0, 1));
        vecs.push_back(mk(ADD,          32'h100,      32'd0,        32'd0,       1, 0, 5'd2,  0, 5'd0, 1, 0, 1, 3'd0, 32'h0,        32'h0,        0, 0));
        vecs.push_back(mk(ADD,          32'h100,      32'd0,        32'd0,       1, 0, 5'd0,  0, 5'd0, 0, 0, 0, 3'd0, 32'h0,        32'h0,        0, 0));
        vecs.push_back(mk(ADD,          32'h100,      32'd0,        32'd0,       1, 0, 5'd1,  0, 5'd0, 1, 0, 1, 3'd0, 32'h0,        32'h0,        0, 0));
        vecs.push_back(mk(ADD,          32'h100,      32'd0,        32'd0,       1, 0, 5'd5,  0, 5'd0, 0, 0, 0, 3'd0, 32'h0,        32'h0,        0, 0));
        vecs.push_back(mk(32'h08400000, 32'h100,      32'd0,        32'd0,       1, 0, 5'd2,  0, 5'd0, 0, 1, 0, 3'd2, 32'h0,        32'h01000000, 0, 1));
        vecs.push_back(mk(BEQ,          32'h100,      32'd5,        32'd5,       0, 1, 5'd1,  0, 5'd0, 1, 0, 1, 3'd0, 32'h10C,      32'h0,        1, 0));
        vecs.push_back(mk(BEQ,          32'h100,      32'd5,        32'd5,       0, 0, 5'd0,  1, 5'd2, 1, 0, 1, 3'd0, 32'h10C,      32'h0,        1, 0));
        vecs.push_back(mk(BEQ,          32'h100,      32'd5,        32'd5,       0, 0, 5'd0,  1, 5'd3, 0, 1, 0, 3'd1, 32'h10C,      32'h0,        1, 0));
        vecs.push_back(mk(ADD,          32'h100,      32'd0,        32'd0,       0, 1, 5'd2,  0, 5'd0, 0, 0, 0, 3'd0, 32'h0,        32'h0,        0, 0));
        vecs.push_back(mk(ADD,          32'h100,      32'd0,        32'd0,       0, 0, 5'd0,  1, 5'd2, 0, 0, 0, 3'd0, 32'h0,        32'h0,        0, 0));
        vecs.push_back(mk(32'h03E00008, 32'h0,        32'h400,      32'd0,       1, 1, 5'd31, 0, 5'd0, 1, 0, 1, 3'd0, 32'h0,        32'h0,        0, 0));
        vecs.push_back(mk(32'h00000000, 32'h4,        32'd0,        32'd0,       0, 0, 5'd0,  0, 5'd0, 0, 0, 0, 3'd0, 32'h0,        32'h0,        0, 0));

        foreach (vecs[i]) begin
            clear_hazards();
            instruction_if = vecs[i].instr;
            pc_plus4_if    = vecs[i].pc4;
            step();
            rs_data_id   = vecs[i].rs_d;
            rt_data_id   = vecs[i].rt_d;
            ex_mem_read  = vecs[i].ex_mr;
            ex_reg_write = vecs[i].ex_rw;
            ex_rd        = vecs[i].ex_rd;
            mem_mem_read = vecs[i].mem_mr;
            mem_rd       = vecs[i].mem_rd;
            e.idx = i; e.instr = vecs[i].instr; e.pc4 = vecs[i].pc4;
            e.stall = vecs[i].stall; e.flush = vecs[i].flush; e.bubble = vecs[i].bubble;
            e.pcsrc = vecs[i].pcsrc; e.baddr = vecs[i].baddr; e.jaddr = vecs[i].jaddr;
            e.chk_b = vecs[i].chk_b; e.chk_j = vecs[i].chk_j;
            sb_q.push_back(e);
            #1;
            e = sb_q.pop_front();
            chk($sformatf("v%0d instruction_id", e.idx), instruction_id, e.instr);
            chk($sformatf("v%0d pc_plus4_id", e.idx), pc_plus4_id, e.pc4);
            chk($sformatf("v%0d stall", e.idx), 32'(stall), 32'(e.stall));
            chk($sformatf("v%0d flush", e.idx), 32'(flush), 32'(e.flush));
            chk($sformatf("v%0d bubble_id", e.idx), 32'(bubble_id), 32'(e.bubble));
            chk($sformatf("v%0d pc_src_id", e.idx), 32'(pc_src_id), 32'(e.pcsrc));
            chk($sformatf("v%0d irq_ack", e.idx), 32'(irq_ack), 32'd0);
            if (e.chk_b) chk($sformatf("v%0d branch_addr_id", e.idx), branch_addr_id, e.baddr);
            if (e.chk_j) chk($sformatf("v%0d jump_addr_id", e.idx), jump_addr_id, e.jaddr);
        end
        chk("scoreboard drained", 32'(sb_q.size()), 32'd0);

        // load-use holds IF/ID, then releases
        clear_hazards();
        instruction_if = ADD; pc_plus4_if = 32'h104;
        step();
        ex_mem_read = 1'b1; ex_rd = 5'd2;
        instruction_if = 32'hDEADBEEF; pc_plus4_if = 32'h108;
        #1;
        chk("lu stall", 32'(stall), 32'd1);
        step();
        chk("lu held instr", instruction_id, ADD);
        chk("lu held pc4", pc_plus4_id, 32'h104);
        clear_hazards();
        #1;
        chk("lu released stall", 32'(stall), 32'd0);
        step();
        chk("lu next instr", instruction_id, 32'hDEADBEEF);
        chk("lu next pc4", pc_plus4_id, 32'h108);

        // jr $31 waits one cycle for $31 in EX, then jumps
        instruction_if = 32'h03E00008; pc_plus4_if = 32'h20;
        step();
        rs_data_id = 32'h400; ex_reg_write = 1'b1; ex_rd = 5'd31;
        instruction_if = 32'h0; pc_plus4_if = 32'h24;
        #1;
        chk("jr stall", 32'(stall), 32'd1);
        chk("jr stall pc_src", 32'(pc_src_id), 32'd0);
        chk("jr stall flush", 32'(flush), 32'd0);
        step();
        clear_hazards();
        #1;
        chk("jr held instr", instruction_id, 32'h03E00008);
        chk("jr go stall", 32'(stall), 32'd0);
        chk("jr go pc_src", 32'(pc_src_id), 32'd2);
        chk("jr go flush", 32'(flush), 32'd1);
        chk("jr go target", jump_addr_id, 32'h400);
        step();

`ifdef IFID_IRQ_EN
        // irq entry latency with add in ID
        instruction_if = ADD; pc_plus4_if = 32'h204;
        step();
        irq = 1'b1;
        step();
        chk("irq n+1 pc_src", 32'(pc_src_id), 32'd0);
        chk("irq n+1 ack", 32'(irq_ack), 32'd0);
        step();
        chk("irq n+2 pc_src", 32'(pc_src_id), 32'd0);
        chk("irq n+2 ack", 32'(irq_ack), 32'd0);
        step();
        chk("irq entry pc_src", 32'(pc_src_id), 32'd3);
        chk("irq entry ack", 32'(irq_ack), 32'd1);
        chk("irq entry flush", 32'(flush), 32'd1);
        chk("irq entry bubble", 32'(bubble_id), 32'd1);
        chk("irq entry stall", 32'(stall), 32'd0);
        step();
        chk("irq epc", epc, 32'h200);
        chk("irq after ack", 32'(irq_ack), 32'd0);
        chk("irq after pc_src", 32'(pc_src_id), 32'd0);
        acks = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            if (irq_ack) acks++;
        end
        chk("irq held no second ack", 32'(acks), 32'd0);
        irq = 1'b0;
        repeat (5) step();

        // entry slips past a beq in ID, then past a load-use stall
        instruction_if = ADD; pc_plus4_if = 32'h304;
        step();
        irq = 1'b1;
        step();
        step();
        instruction_if = BEQ; pc_plus4_if = 32'h400;
        rs_data_id = 32'd5; rt_data_id = 32'd6;
        step();
        chk("defer beq instr", instruction_id, BEQ);
        chk("defer beq pc_src", 32'(pc_src_id), 32'd0);
        chk("defer beq ack", 32'(irq_ack), 32'd0);
        instruction_if = ADD; pc_plus4_if = 32'h304;
        step();
        ex_mem_read = 1'b1; ex_rd = 5'd2;
        #1;
        chk("defer stall", 32'(stall), 32'd1);
        chk("defer stall ack", 32'(irq_ack), 32'd0);
        chk("defer stall pc_src", 32'(pc_src_id), 32'd0);
        step();
        chk("defer stall2 ack", 32'(irq_ack), 32'd0);
        clear_hazards();
        #1;
        chk("defer entry pc_src", 32'(pc_src_id), 32'd3);
        chk("defer entry ack", 32'(irq_ack), 32'd1);
        step();
        chk("defer epc", epc, 32'h300);
        irq = 1'b0;
        repeat (5) step();
`else
        // irq has no effect without the interrupt logic
        instruction_if = ADD; pc_plus4_if = 32'h204;
        step();
        irq = 1'b1;
        bad = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (irq_ack || (pc_src_id == 3'd3) || (epc != 32'h0)) bad++;
        end
        chk("irq disabled no trap", 32'(bad), 32'd0);
        irq = 1'b0;
        step();
`endif

        // reset mid-run with an interrupt pending (nop in ID blocks entry)
        instruction_if = 32'h0; pc_plus4_if = 32'h500;
        irq = 1'b1;
        repeat (4) step();
        #2;
        reset = 1'b1;
        irq = 1'b0;
        #1;
        chk("mid rst instruction_id", instruction_id, 32'h0);
        chk("mid rst pc_plus4_id", pc_plus4_id, 32'h0);
        chk("mid rst epc", epc, 32'h0);
        chk_idle_ctrl("mid rst");
        instruction_if = ADD; pc_plus4_if = 32'h604;
        step();
        chk("rst held instruction_id", instruction_id, 32'h0);
        reset = 1'b0;
        step();
        chk("post rst load instr", instruction_id, ADD);
        chk("post rst load pc4", pc_plus4_id, 32'h604);
        acks = 0;
        for (int k = 0; k < 6; k++) begin
            #1;
            if (irq_ack) acks++;
            step();
        end
        chk("pending lost after reset", 32'(acks), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
